// File: rtl/if_fetch_unit.sv
// IF stage: owns the fetch PC, runs a single-outstanding req/gnt/rvalid
// fetch, and buffers responses in an output register plus a 1-entry skid.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        discard_q, discard_d;
  logic        consume;

  assign consume = out_valid_q & ~stall_i;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    discard_d    = discard_q;

    if (consume) begin
      if (skid_valid_q) begin
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!skid_valid_q) state_d = REQ;
      end
      REQ: begin
        if (imem_gnt_i) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
          if (discard_q) begin
            discard_d = 1'b0;
          end else if (!out_valid_q || consume) begin
            out_valid_d = 1'b1;
            out_instr_d = imem_rdata_i;
            out_pc_d    = req_pc_q;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata_i;
            skid_pc_d    = req_pc_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; in-flight work becomes wrong-path.
    if (redirect_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      fetch_pc_d   = redirect_pc_i & ~32'd3;
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt_i) begin
            state_d   = WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state_d   = REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'd0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      discard_q    <= discard_d;
    end
  end

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = fetch_pc_q;
  assign if_valid_o  = out_valid_q;
  assign if_instr_o  = out_valid_q ? out_instr_q : NOP_INSTR;
  assign pc_o        = out_valid_q ? out_pc_q : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model plus a queue of the instructions
// expected in the output register and skid buffer.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] pc_o;

  if_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];
  bit          pending = 0;
  bit          pend_wrong = 0;
  logic [31:0] pend_addr = 0;
  int          pend_age = 0;
  int          rv_lat = 0;
  int          gnt_stall = 0;
  bit          hold_rv = 0;
  bit          rnd = 0;

  bit          p_rst, p_cons, p_redir, p_g, p_v;
  logic [31:0] p_addr;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic update();
    if (p_cons && !p_redir) void'(q.pop_front());
    if (p_v && pending) begin
      if (!pend_wrong) q.push_back(pend_addr);
      pending = 0;
    end
    if (p_g) begin
      pending    = 1;
      pend_addr  = p_addr;
      pend_wrong = 0;
      pend_age   = 0;
      if (rnd) begin
        gnt_stall = $urandom_range(0, 2);
        rv_lat    = $urandom_range(0, 2);
      end
    end
    if (p_redir) begin
      q.delete();
      if (pending) pend_wrong = 1;
    end
  endtask

  task automatic check_out();
    check("valid", {31'd0, if_valid_o}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("pc", pc_o, q[0]);
      check("instr", if_instr_o, memdata(q[0]));
    end else begin
      check("nop", if_instr_o, NOP);
      check("pc0", pc_o, 32'd0);
    end
  endtask

  task automatic drive_mem();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEAD_BEEF;
    if (imem_req_o) begin
      if (gnt_stall > 0) gnt_stall--;
      else imem_gnt_i = 1'b1;
    end
    if (pending && !hold_rv) begin
      if (pend_age >= rv_lat) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = memdata(pend_addr);
      end else begin
        pend_age++;
      end
    end
  endtask

  task automatic cyc();
    p_rst   = rst_i;
    p_cons  = (q.size() != 0) && !stall_i;
    p_redir = redirect_i;
    p_g     = imem_req_o && imem_gnt_i;
    p_addr  = imem_addr_o;
    p_v     = imem_rvalid_i;
    @(negedge clk);
    redirect_i = 1'b0;
    if (!p_rst && !rst_i) update();
    if (!rst_i) check_out();
    drive_mem();
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    q.delete();
    pending   = 0;
    gnt_stall = 0;
    #1;
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'd0);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_instr", if_instr_o, NOP);
    check("rst_pc", pc_o, 32'd0);
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  initial begin
    int n;
    @(negedge clk);
    do_reset();

    cyc();
    check("first_req", {31'd0, imem_req_o}, 32'd1);
    check("first_addr", imem_addr_o, 32'd0);
    cyc();
    check("wait_req", {31'd0, imem_req_o}, 32'd0);
    check("next_addr", imem_addr_o, 32'd4);
    cyc();
    check("first_instr", if_instr_o, 32'h0050_0093);
    check("first_pc", pc_o, 32'd0);

    stall_i = 1'b1;
    repeat (4) cyc();
    check("skid_noreq", {31'd0, imem_req_o}, 32'd0);
    check("stall_pc", pc_o, 32'd0);
    stall_i = 1'b0;
    cyc();
    check("drain_pc", pc_o, 32'd4);
    n = 0;
    while (!(if_valid_o && pc_o != 32'd4) && n < 20) begin cyc(); n++; end
    check("to_pc8", {31'd0, n >= 20}, 32'd0);
    check("third_pc", pc_o, 32'd8);

    hold_rv = 1;
    n = 0;
    while (!pending && n < 20) begin cyc(); n++; end
    check("to_wait", {31'd0, n >= 20}, 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    cyc();
    cyc();
    cyc();
    hold_rv = 0;
    cyc();
    cyc();
    n = 0;
    while (!imem_req_o && n < 20) begin cyc(); n++; end
    check("redir_addr", imem_addr_o, 32'h0000_0100);
    n = 0;
    while (!if_valid_o && n < 20) begin cyc(); n++; end
    check("redir_pc", pc_o, 32'h0000_0100);

    n = 0;
    while (!imem_rvalid_i && n < 20) begin cyc(); n++; end
    check("to_rv", {31'd0, n >= 20}, 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    cyc();
    check("same_valid", {31'd0, if_valid_o}, 32'd0);
    n = 0;
    while (!imem_req_o && n < 20) begin cyc(); n++; end
    check("align_addr", imem_addr_o, 32'h0000_0100);

    gnt_stall     = 3;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    n = 0;
    while (!(imem_req_o && imem_addr_o == 32'hFFFF_FFFC) && n < 20) begin
      cyc();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check("wrap_req", {31'd0, imem_req_o}, 32'd1);
      check("wrap_hold", imem_addr_o, 32'hFFFF_FFFC);
      cyc();
    end
    check("wrap_gnt", imem_addr_o, 32'hFFFF_FFFC);
    cyc();
    check("wrap_addr", imem_addr_o, 32'd0);

    rnd = 1;
    for (int i = 0; i < 400; i++) begin
      stall_i = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 29) == 0) begin
        redirect_i    = 1'b1;
        redirect_pc_i = $urandom;
      end
      cyc();
    end
    rnd       = 0;
    stall_i   = 1'b0;
    gnt_stall = 0;
    rv_lat    = 0;

    hold_rv = 1;
    n = 0;
    while (!pending && n < 20) begin cyc(); n++; end
    check("to_wait2", {31'd0, n >= 20}, 32'd0);
    do_reset();
    hold_rv       = 0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_BAD0;
    cyc();
    check("post_req", {31'd0, imem_req_o}, 32'd1);
    check("post_addr", imem_addr_o, 32'd0);
    n = 0;
    while (!if_valid_o && n < 20) begin cyc(); n++; end
    check("post_pc", pc_o, 32'd0);
    check("post_instr", if_instr_o, 32'h0050_0093);
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
